// File: rtl/cpu_mc.sv
`default_nettype none
// ============================================================================
// Module : cpu_mc
// Multi-cycle CPU: handshaked 16-bit fetch, 16-entry register file, Z/V/N flags.
// Rev    : 1.0
// ============================================================================
module cpu_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [15:0]       imem_data,
    output logic              hlt,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [2:0]        dbg_flags
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam int         c_MSB    = DATA_W - 1;
    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_AND = 4'h2;
    localparam logic [3:0] c_OP_NOR = 4'h3;
    localparam logic [3:0] c_OP_SLL = 4'h4;
    localparam logic [3:0] c_OP_SRL = 4'h5;
    localparam logic [3:0] c_OP_SRA = 4'h6;
    localparam logic [3:0] c_OP_LLB = 4'h7;
    localparam logic [3:0] c_OP_B   = 4'hC;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] regs_q [16];
    logic              z_q, v_q, n_q;
    logic              z_d, v_d, n_d;
    logic              req_q, hlt_q;

    logic [3:0]        op, rd, rs, rt;
    logic [DATA_W-1:0] rs_val, rt_val, res_d;
    logic              wr_d, halt_d, taken;
    logic [ADDR_W+8:0] off_ext;

    assign op      = ir_q[15:12];
    assign rd      = ir_q[11:8];
    assign rs      = ir_q[7:4];
    assign rt      = ir_q[3:0];
    // Entry 0 is reset to zero and never written, so it reads as R0 directly.
    assign rs_val  = regs_q[rs];
    assign rt_val  = regs_q[rt];
    assign off_ext = {{ADDR_W{ir_q[8]}}, ir_q[8:0]};

    always_comb begin
        taken = 1'b0;
        case (ir_q[11:9])
            3'b000:  taken = !z_q;
            3'b001:  taken = z_q;
            3'b010:  taken = !z_q && !n_q;
            3'b011:  taken = n_q;
            3'b100:  taken = !n_q;
            3'b101:  taken = z_q || n_q;
            3'b110:  taken = v_q;
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        res_d  = '0;
        wr_d   = 1'b0;
        halt_d = 1'b0;
        z_d    = z_q;
        v_d    = v_q;
        n_d    = n_q;
        pc_d   = pc_q + ADDR_W'(1);
        case (op)
            c_OP_ADD: begin
                res_d = rs_val + rt_val;
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
                n_d   = res_d[c_MSB];
                v_d   = (rs_val[c_MSB] == rt_val[c_MSB]) && (res_d[c_MSB] != rs_val[c_MSB]);
            end
            c_OP_SUB: begin
                res_d = rs_val - rt_val;
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
                n_d   = res_d[c_MSB];
                v_d   = (rs_val[c_MSB] != rt_val[c_MSB]) && (res_d[c_MSB] != rs_val[c_MSB]);
            end
            c_OP_AND: begin
                res_d = rs_val & rt_val;
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
            end
            c_OP_NOR: begin
                res_d = ~(rs_val | rt_val);
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
            end
            // Shift amount is the raw rt field, not the register it names.
            c_OP_SLL: begin
                res_d = rs_val << rt;
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
            end
            c_OP_SRL: begin
                res_d = rs_val >> rt;
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
            end
            c_OP_SRA: begin
                res_d = $signed(rs_val) >>> rt;
                wr_d  = 1'b1;
                z_d   = (res_d == '0);
            end
            c_OP_LLB: begin
                res_d = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
                wr_d  = 1'b1;
            end
            c_OP_B: begin
                if (taken) begin
                    pc_d = pc_q + ADDR_W'(1) + off_ext[ADDR_W-1:0];
                end
            end
            c_OP_HLT: begin
                halt_d = 1'b1;
                pc_d   = pc_q;
            end
            default: begin
                pc_d = pc_q + ADDR_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            req_q   <= 1'b1;
            hlt_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_rdy) begin
                        ir_q    <= imem_data;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                    end
                end
                S_EXEC: begin
                    pc_q <= pc_d;
                    z_q  <= z_d;
                    v_q  <= v_d;
                    n_q  <= n_d;
                    if (wr_d && (rd != 4'd0)) begin
                        regs_q[rd] <= res_d;
                    end
                    if (halt_d) begin
                        state_q <= S_HALT;
                        hlt_q   <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    hlt_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign dbg_pc    = pc_q;
    assign hlt       = hlt_q;
    assign dbg_flags = {z_q, v_q, n_q};

endmodule
`default_nettype wire

// File: tb/tb_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_mc
// Directed and random instruction streams against an arithmetic reference model.
// Rev    : 1.0
// ============================================================================
module tb_cpu_mc;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        hlt;
    logic [15:0] dbg_pc;
    logic [2:0]  dbg_flags;

    logic        w_req;
    logic [7:0]  w_addr;
    logic        w_rdy;
    logic [15:0] w_data;
    logic        w_hlt;
    logic [7:0]  w_pc;
    logic [2:0]  w_flags;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_regs [16];
    int          m_pc;
    bit          m_z, m_v, m_n, m_halt;
    logic [3:0]  nop_ops [6] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};

    cpu_mc #(.DATA_W(16), .ADDR_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdy  (imem_rdy),
        .imem_data (imem_data),
        .hlt       (hlt),
        .dbg_pc    (dbg_pc),
        .dbg_flags (dbg_flags)
    );

    cpu_mc #(.DATA_W(32), .ADDR_W(8)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (w_req),
        .imem_addr (w_addr),
        .imem_rdy  (w_rdy),
        .imem_data (w_data),
        .hlt       (w_hlt),
        .dbg_pc    (w_pc),
        .dbg_flags (w_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
    endtask

    // Architectural meaning of each opcode, worked in signed/unsigned integers.
    task automatic model_exec(input logic [15:0] ins);
        int op, rd, rs, rt, nxt, off, imm;
        longint a, b, sa, sb, r;
        bit wr, take;
        op = int'(ins[15:12]); rd = int'(ins[11:8]);
        rs = int'(ins[7:4]);   rt = int'(ins[3:0]);
        a  = longint'(m_regs[rs]); b = longint'(m_regs[rt]);
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r = 0; wr = 0; take = 0;
        nxt = (m_pc + 1) % 65536;
        if (op == 0 || op == 1) begin
            r = (op == 0) ? sa + sb : sa - sb;
            m_v = (r > 32767) || (r < -32768);
            r = r & 64'hFFFF;
            m_z = (r == 0); m_n = (r >= 32768); wr = 1;
        end else if (op >= 2 && op <= 6) begin
            case (op)
                2: r = a & b;
                3: r = ~(a | b) & 64'hFFFF;
                4: r = (a << rt) & 64'hFFFF;
                5: r = a >> rt;
                default: r = (sa >>> rt) & 64'hFFFF;
            endcase
            m_z = (r == 0); wr = 1;
        end else if (op == 7) begin
            imm = int'(ins[7:0]);
            r = (imm >= 128) ? imm + 65280 : imm;
            wr = 1;
        end else if (op == 12) begin
            case (int'(ins[11:9]))
                0: take = !m_z;
                1: take = m_z;
                2: take = !m_z && !m_n;
                3: take = m_n;
                4: take = !m_n;
                5: take = m_z || m_n;
                6: take = m_v;
                default: take = 1;
            endcase
            off = int'(ins[8:0]);
            if (off >= 256) off -= 512;
            if (take) nxt = (m_pc + 1 + off + 65536) % 65536;
        end else if (op == 15) begin
            m_halt = 1; nxt = m_pc;
        end
        if (wr && rd != 0) m_regs[rd] = r[15:0];
        m_pc = nxt;
    endtask

    // Entered and left on a falling edge with the DUT waiting in fetch.
    task automatic run_instr(input logic [15:0] ins, input int waits);
        logic [3:0] rd;
        rd = ins[11:8];
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        imem_rdy = 1'b0;
        for (int i = 0; i < waits; i++) begin
            imem_data = 16'($urandom);
            @(negedge clk);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", 32'(imem_addr), 32'(m_pc));
        end
        imem_rdy  = 1'b1;
        imem_data = ins;
        @(negedge clk);
        check("exec_req", 32'(imem_req), 32'd0);
        imem_rdy  = 1'($urandom);
        imem_data = 16'($urandom);
        @(negedge clk);
        imem_rdy = 1'b0;
        model_exec(ins);
        check("pc", 32'(dbg_pc), 32'(m_pc));
        check("flags", 32'(dbg_flags), 32'({m_z, m_v, m_n}));
        check("hlt", 32'(hlt), 32'(m_halt));
        check("req_next", 32'(imem_req), 32'(!m_halt));
        if (ins[15:12] <= 4'd7) check("rd_val", 32'(u_dut.regs_q[rd]), 32'(m_regs[rd]));
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_hlt"}, 32'(hlt), 32'd0);
        check({tag, "_pc"}, 32'(dbg_pc), 32'd0);
        check({tag, "_flags"}, 32'(dbg_flags), 32'd0);
        for (int i = 1; i < 16; i++) check({tag, "_reg"}, 32'(u_dut.regs_q[i]), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        reset_outputs("rst");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wstep(input logic [15:0] ins, input int fetch_pc, input int exp_pc);
        check("w_req", 32'(w_req), 32'd1);
        check("w_addr", 32'(w_addr), 32'(fetch_pc));
        w_rdy  = 1'b1;
        w_data = ins;
        @(negedge clk);
        w_rdy = 1'b0;
        @(negedge clk);
        check("w_pc", 32'(w_pc), 32'(exp_pc));
    endtask

    initial begin
        rst_n = 1'b0; imem_rdy = 1'b0; imem_data = 16'h0;
        w_rdy = 1'b0; w_data = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_outputs("por");
        rst_n = 1'b1;

        // Overflowing add
        run_instr(16'h717F, 0);
        run_instr(16'h4118, 0);
        run_instr(16'h0211, 0);
        check("arith_r1", 32'(u_dut.regs_q[1]), 32'h7F00);
        check("arith_r2", 32'(u_dut.regs_q[2]), 32'hFE00);
        check("arith_flags", 32'(dbg_flags), 32'b011);

        // Branches from PC 10, with three wait states per fetch
        for (int i = 0; i < 6; i++) run_instr({nop_ops[i], 12'($urandom)}, 0);
        run_instr(16'h1311, 3);
        run_instr(16'hC203, 3);
        check("beq_taken", 32'(dbg_pc), 32'd14);
        run_instr(16'hCFFB, 3);
        run_instr(16'hC003, 3);
        check("bne_not_taken", 32'(dbg_pc), 32'd11);
        run_instr(16'hCFFE, 3);
        run_instr(16'hCFF5, 3);
        check("b_always_back", 32'(dbg_pc), 32'd0);

        // R0 and shifts
        run_instr(16'h7055, 0);
        run_instr(16'h0700, 0);
        check("r0_zero", 32'(u_dut.regs_q[7]), 32'd0);
        check("r0_zflag", 32'(dbg_flags[2]), 32'd1);
        run_instr(16'h7480, 1);
        run_instr(16'h6544, 2);
        check("sra", 32'(u_dut.regs_q[5]), 32'hFFF8);
        run_instr(16'h5644, 0);
        check("srl", 32'(u_dut.regs_q[6]), 32'h0FF8);

        // Random programs
        for (int n = 0; n < 150; n++) begin
            run_instr({4'($urandom_range(0, 14)), 12'($urandom)}, int'($urandom_range(0, 3)));
        end
        for (int i = 1; i < 16; i++) check("sweep", 32'(u_dut.regs_q[i]), 32'(m_regs[i]));

        // Asynchronous reset while stalled in fetch at PC 5
        do_reset();
        run_instr(16'h7180, 0);
        run_instr(16'h0210, 0);
        for (int i = 0; i < 3; i++) run_instr({nop_ops[i + 3], 12'($urandom)}, 0);
        imem_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_addr", 32'(imem_addr), 32'd5);
        end
        check("pre_rst_flags", 32'(dbg_flags), 32'b001);
        #2 rst_n = 1'b0;
        #1 reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Halt at PC 7
        for (int i = 0; i < 7; i++) run_instr({nop_ops[i % 6], 12'($urandom)}, 0);
        run_instr(16'hF000, 1);
        for (int i = 0; i < 20; i++) begin
            imem_rdy = 1'($urandom);
            @(negedge clk);
            check("halt_hlt", 32'(hlt), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_pc", 32'(dbg_pc), 32'd7);
        end
        imem_rdy = 1'b0;

        // 32-bit data, 8-bit PC: wrap past 255
        wstep(16'hCFFE, 0, 255);
        wstep(16'h7180, 255, 0);
        check("w_llb", u_dut_w.regs_q[1], 32'hFFFF_FF80);
        wstep(16'h0211, 0, 1);
        check("w_add", u_dut_w.regs_q[2], 32'hFFFF_FF00);
        check("w_flags", 32'(w_flags), 32'b001);
        wstep(16'hF000, 1, 1);
        check("w_hlt", 32'(w_hlt), 32'd1);
        check("w_req_halt", 32'(w_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mc.md
# cpu_mc

Parametrised multi-cycle successor to the single-cycle CPU top. It fetches 16-bit instructions over a ready/request handshake, so instruction memory may insert wait states. It executes one instruction per fetch/execute pair against a 16-entry register file of configurable width, and keeps Z/V/N flags for conditional branches. It asserts `hlt` on HLT and freezes until reset.

## Interface
- `DATA_W`, 16: register/ALU width; legal 16..32.
- `ADDR_W`, 16: PC / instruction address width.
- `clk  in  1`: clock; all state changes on rising edge.
- `rst_n  in  1`: asynchronous active-low reset.
- `imem_req  out  1`: fetch request.
- `imem_addr  out  ADDR_W`: fetch address, equal to the PC.
- `imem_rdy  in  1`: `imem_data` is valid this cycle.
- `imem_data  in  16`: instruction word.
- `hlt  out  1`: halted.
- `dbg_pc  out  ADDR_W`: current PC.
- `dbg_flags  out  3`: {Z, V, N}.

## Operation
- **Instruction fields:** op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0].
- **R0:** reads return 0; writes are discarded.
- **Register file:** R1..R15 reset to 0.
- **Arithmetic ops** (update Z, V, N; result wraps mod 2^DATA_W):
  - 0 ADD: rd=rs+rt.
  - 1 SUB: rd=rs−rt.
  - V is signed overflow.
- **Logical and shift ops** (update Z only; V and N hold):
  - 2 AND: rd=rs&rt.
  - 3 NOR: rd=~(rs|rt).
  - 4 SLL: rd=rs<<rt field (shamt 0..15).
  - 5 SRL: logical right shift, same shamt.
  - 6 SRA: arithmetic right shift, same shamt.
- **Immediate:** 7 LLB: rd=sign-extend(imm8); flags unchanged.
- **Branch:** 12 B.
  - cond=[11:9]:
    - 000 NE (!Z)
    - 001 EQ (Z)
    - 010 GT (!Z&!N)
    - 011 LT (N)
    - 100 GE (!N)
    - 101 LE (Z|N)
    - 110 OV (V)
    - 111 always
  - Offset=[8:0] is signed.
  - Taken: PC=PC+1+sext(offset). Not taken: PC=PC+1.
  - PC arithmetic is mod 2^ADDR_W.
- **Halt:** 15 HLT sets `hlt`; PC is not advanced.
- **Other opcodes** (8–11, 13, 14): NOP; PC=PC+1.
- **Flags:** Z, V, N reset to 0. Z means result==0; N is result MSB.
- **FSM states:** FETCH, EXEC, HALT.
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_rdy`, latch `imem_data` into IR and go to EXEC. Otherwise stay; address is held stable.
  - EXEC: compute; write rd and flags at the clock edge; update PC; go to FETCH. For HLT, go to HALT instead.
  - HALT: `imem_req`=0, `hlt`=1. Stay until reset; `imem_rdy` is ignored.
- **Reset (any state, including mid-fetch):** state=FETCH, PC=0, IR=0, flags=0, regs=0, `hlt`=0.
- Register file reads use IR fields combinationally in EXEC. Writes take effect at the end of EXEC, so the next instruction sees the new value; no forwarding is needed.

## Timing
- **Reset values:** `imem_req`=1 (FETCH state), `imem_addr`=0, `hlt`=0, `dbg_pc`=0, `dbg_flags`=000.
- **Throughput:** 2 cycles per instruction with zero-wait memory; each wait cycle (rdy=0) adds 1.
- **Handshake:**
  - `imem_req` and `imem_addr` are Moore outputs of the FSM.
  - `imem_rdy` is sampled only while `imem_req`=1.
  - `imem_rdy` outside FETCH has no effect.
- **`hlt` timing:** rises on the edge that ends the HLT's EXEC cycle. `dbg_pc` then remains at the HLT address.
- **Write timing:** register and flag writes happen on the same edge as the PC update.

## Test plan
- **Reset mid-fetch:** hold `imem_rdy`=0 with PC=5, pulse `rst_n` low → `imem_addr`=0, `hlt`=0, flags=000, all regs 0 asynchronously.
- **Arithmetic and overflow (DATA_W=16):** LLB R1,0x7F; SLL R1,R1,8; ADD R2,R1,R1 → R1=0x7F00, R2=0xFE00, V=1, N=1, Z=0.
- **Branch taken/not-taken:** SUB R3,R1,R1 (Z=1); B EQ,+3 at PC=10 → next fetch at 14. Same with NE → next fetch at 11. B always, offset −11 at PC=10 → next fetch at 0.
- **Wait states:** `imem_rdy` low for 3 cycles per fetch → each instruction takes 5 cycles; `imem_addr` is stable throughout; results match zero-wait run.
- **R0 and shifts:** LLB R0,0x55 → R0 reads 0. LLB R4,0x80; SRA R5,R4,4 → R5=0xFFF8. SRL R6,R4,4 → R6=0x0FF8.
- **Halt:** HLT at PC=7 → `hlt`=1, `imem_req`=0, `dbg_pc`=7, held for 20 cycles despite `imem_rdy` toggling. Repeat with DATA_W=32 and ADDR_W=8: PC wraps from 255 to 0.
